// File: rtl/of_lookup_arbiter_pkg.sv
// of_pkg: shared widths, port mask and FSM encoding for the flow-table lookup arbiter
package of_pkg;
  localparam int KEYW = 116;
  localparam int NPORT = 4;
  localparam logic [NPORT-1:0] OF_PORT_ALL = '1;
  typedef enum logic {S_IDLE, S_WAIT} state_e;
endpackage

// File: rtl/of_lookup_arbiter_rr_pick.sv
// rr_pick: round-robin priority encoder, first set request after ptr_i with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] j;
  // scan farthest-first so the nearest candidate after ptr_i is the last to win
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        idx_o = j;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/of_lookup_arbiter.sv
// of_lookup_arbiter: shares one flow-table lookup engine among NREQ forwarders, round-robin
module of_lookup_arbiter #(
  parameter int NREQ = 4,
  parameter int NPORT = of_pkg::NPORT,
  parameter int KEYW = of_pkg::KEYW,
  parameter int TMO_W = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NREQ-1:0]      rq_req,
  input  logic [NREQ*KEYW-1:0] rq_data,
  output logic [NREQ-1:0]      rq_ack,
  output logic [NREQ-1:0]      rq_err,
  output logic [NPORT-1:0]     rq_fwd_port,
  output logic                 tbl_req,
  output logic [KEYW-1:0]      tbl_data,
  input  logic                 tbl_ack,
  input  logic                 tbl_err,
  input  logic [NPORT-1:0]     tbl_fwd_port,
  output logic                 busy,
  output logic [NREQ-1:0]      overrun
);
  import of_pkg::*;
  localparam int IW = $clog2(NREQ);
  state_e state_q, state_d;
  logic [NREQ-1:0] pend_q, pend_d, ovr_q, ovr_d, ack_q, ack_d, err_q, err_d, clr;
  logic [NREQ-1:0][KEYW-1:0] key_q, key_d;
  logic [IW-1:0] ptr_q, ptr_d, g;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [NPORT-1:0] fwd_q, fwd_d;
  logic [KEYW-1:0] tdat_q, tdat_d;
  logic treq_q, treq_d, gv, hit, miss;

  rr_pick #(.N(NREQ)) u_pick (.req_i(pend_q), .ptr_i(ptr_q), .idx_o(g), .valid_o(gv));

  // ptr_q holds the granted index for the whole WAIT phase
  assign hit = (state_q == S_WAIT) && tbl_ack;
  assign miss = (state_q == S_WAIT) && !tbl_ack && (tbl_err || &tmo_d);
  assign clr = (hit || miss) ? NREQ'(1) << ptr_q : '0;

  always_comb begin
    pend_d = (pend_q & ~clr) | rq_req;
    ovr_d = ovr_q | (rq_req & pend_q & ~clr);
    for (int i = 0; i < NREQ; i++)
      key_d[i] = (rq_req[i] && !(pend_q[i] && !clr[i])) ? rq_data[i*KEYW +: KEYW] : key_q[i];
    state_d = state_q;
    ptr_d = ptr_q;
    tmo_d = tmo_q + 1'b1;
    tdat_d = tdat_q;
    treq_d = 1'b0;
    ack_d = '0;
    err_d = '0;
    fwd_d = fwd_q;
    if (state_q == S_IDLE && gv) begin
      tdat_d = key_q[g];
      treq_d = 1'b1;
      ptr_d = g;
      state_d = S_WAIT;
    end else if (hit) begin
      ack_d = clr;
      fwd_d = tbl_fwd_port;
      state_d = S_IDLE;
    end else if (miss) begin
      err_d = clr;
      fwd_d = '0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      pend_q <= '0;
      ovr_q <= '0;
      key_q <= '0;
      ptr_q <= IW'(NREQ - 1);
      tmo_q <= '0;
      tdat_q <= '0;
      treq_q <= 1'b0;
      ack_q <= '0;
      err_q <= '0;
      fwd_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      key_q <= key_d;
      ptr_q <= ptr_d;
      tmo_q <= (state_q == S_IDLE && gv) ? '0 : tmo_d;
      tdat_q <= tdat_d;
      treq_q <= treq_d;
      ack_q <= ack_d;
      err_q <= err_d;
      fwd_q <= fwd_d;
    end
  end

  assign rq_ack = ack_q;
  assign rq_err = err_q;
  assign rq_fwd_port = fwd_q;
  assign tbl_req = treq_q;
  assign tbl_data = tdat_q;
  assign busy = state_q == S_WAIT;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_of_lookup_arbiter.sv
// tb_of_lookup_arbiter: directed plus randomized checks against a transaction-level model
module tb_of_lookup_arbiter;
  import of_pkg::*;
  localparam int NREQ = 4;
  localparam int KW = KEYW;
  localparam int NP = NPORT;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [NREQ-1:0] rq_req = '0, rq_ack, rq_err, overrun;
  logic [NREQ*KW-1:0] rq_data = '0;
  logic [NP-1:0] rq_fwd_port, tbl_fwd_port = '0;
  logic tbl_req, tbl_ack = 1'b0, tbl_err = 1'b0, busy;
  logic [KW-1:0] tbl_data;

  logic [NREQ-1:0] pend_m, ovr_m;
  logic [KW-1:0] key_m [NREQ];
  int ptr_m;
  int checks = 0, passed = 0;

  always #5 sys_clk = ~sys_clk;

  of_lookup_arbiter #(.NREQ(NREQ), .NPORT(NP), .KEYW(KW), .TMO_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rq_req(rq_req), .rq_data(rq_data),
    .rq_ack(rq_ack), .rq_err(rq_err), .rq_fwd_port(rq_fwd_port), .tbl_req(tbl_req),
    .tbl_data(tbl_data), .tbl_ack(tbl_ack), .tbl_err(tbl_err), .tbl_fwd_port(tbl_fwd_port),
    .busy(busy), .overrun(overrun)
  );

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  function automatic logic [KW-1:0] rkey();
    return KW'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  function automatic int exp_grant();
    for (int k = 1; k <= NREQ; k++)
      if (pend_m[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    pend_m = '0;
    ovr_m = '0;
    ptr_m = NREQ - 1;
    for (int i = 0; i < NREQ; i++) key_m[i] = '0;
  endtask

  task automatic pulse(input logic [NREQ-1:0] m, input bit fixed, input logic [KW-1:0] fk);
    logic [KW-1:0] k;
    for (int i = 0; i < NREQ; i++) begin
      if (m[i]) begin
        k = fixed ? fk : rkey();
        rq_data[i*KW +: KW] = k;
        if (pend_m[i]) ovr_m[i] = 1'b1;
        else begin
          pend_m[i] = 1'b1;
          key_m[i] = k;
        end
      end
    end
    rq_req = m;
    tick();
    rq_req = '0;
  endtask

  task automatic serve(input int kind, input int dly, input logic [NP-1:0] fwd, input bit re);
    int g, n;
    bit ack;
    logic [NREQ-1:0] oh;
    logic [KW-1:0] k;
    g = exp_grant();
    n = 0;
    while (tbl_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("tbl_req_seen", tbl_req, 1);
    chk("grant_key", tbl_data, key_m[g]);
    chk("busy_wait", busy, 1);
    ack = (kind == 0) || (kind == 2);
    if (kind == 3) begin
      n = 0;
      while (rq_err === '0 && n < 300) begin
        tick();
        n++;
      end
      chk("tmo_cycles", n, 255);
    end else begin
      repeat (dly) tick();
      chk("tbl_data_stable", tbl_data, key_m[g]);
      tbl_ack = ack;
      tbl_err = kind != 0;
      tbl_fwd_port = fwd;
      tick();
      tbl_ack = 1'b0;
      tbl_err = 1'b0;
      tbl_fwd_port = NP'($urandom());
    end
    oh = NREQ'(1) << g;
    chk("rq_ack", rq_ack, ack ? oh : '0);
    chk("rq_err", rq_err, ack ? '0 : oh);
    chk("rq_fwd_port", rq_fwd_port, ack ? fwd : '0);
    chk("busy_done", busy, 0);
    chk("tbl_req_done", tbl_req, 0);
    pend_m[g] = 1'b0;
    ptr_m = g;
    chk("overrun", overrun, ovr_m);
    if (re) begin
      k = rkey();
      rq_data[g*KW +: KW] = k;
      rq_req = oh;
      pend_m[g] = 1'b1;
      key_m[g] = k;
      tick();
      rq_req = '0;
      chk("ack_pulse", rq_ack, 0);
    end else if (pend_m != '0) begin
      tick();
      chk("next_req_m2", tbl_req, 1);
    end
  endtask

  initial begin
    logic [NREQ-1:0] m;
    logic [KW-1:0] ka, kb;
    model_reset();
    repeat (3) tick();
    chk("rst_ack", rq_ack, 0);
    chk("rst_err", rq_err, 0);
    chk("rst_fwd", rq_fwd_port, 0);
    chk("rst_treq", tbl_req, 0);
    chk("rst_tdata", tbl_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    sys_rst = 1'b0;
    tick();

    ka = {29{4'hA}};
    pulse(4'b0100, 1, ka);
    chk("lat_n1", tbl_req, 0);
    tick();
    chk("lat_n2", tbl_req, 1);
    chk("single_key", tbl_data, ka);
    serve(0, 3, 4'b0101, 0);

    pulse(4'b1111, 0, '0);
    serve(0, 0, 4'b0001, 0);
    serve(0, 1, OF_PORT_ALL, 0);
    serve(0, 2, 4'b0100, 0);
    serve(0, 0, 4'b1000, 0);
    pulse(4'b1010, 0, '0);
    serve(0, 1, 4'b0011, 0);
    serve(0, 0, 4'b1100, 0);

    pulse(4'b0010, 0, '0);
    serve(1, 2, 4'b1111, 0);
    pulse(4'b0010, 0, '0);
    serve(2, 1, 4'b0110, 0);

    pulse(NREQ'(1) << $urandom_range(0, NREQ - 1), 0, '0);
    serve(3, 0, 4'b0000, 0);
    tbl_ack = 1'b1;
    tbl_fwd_port = 4'b1001;
    tick();
    tbl_ack = 1'b0;
    tick();
    chk("stale_ack", rq_ack, 0);
    chk("stale_busy", busy, 0);

    ka = rkey();
    kb = rkey();
    pulse(4'b0001, 1, ka);
    pulse(4'b0001, 1, kb);
    chk("ovr_sticky", overrun, 4'b0001);
    serve(0, 1, 4'b0010, 1);
    serve(0, 0, 4'b0100, 0);

    pulse(4'b1000, 0, '0);
    tick();
    tick();
    chk("rst_mid_busy_pre", busy, 1);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    model_reset();
    chk("rstw_ack", rq_ack, 0);
    chk("rstw_err", rq_err, 0);
    chk("rstw_fwd", rq_fwd_port, 0);
    chk("rstw_treq", tbl_req, 0);
    chk("rstw_tdata", tbl_data, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_ovr", overrun, 0);
    tbl_ack = 1'b1;
    tick();
    tbl_ack = 1'b0;
    tick();
    chk("rstw_stale_ack", rq_ack, 0);
    chk("rstw_no_req", tbl_req, 0);
    chk("rstw_idle", busy, 0);
    pulse(4'b0011, 0, '0);
    serve(0, 0, 4'b0001, 0);
    serve(0, 0, 4'b0010, 0);

    repeat (25) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      pulse(m, 0, '0);
      if ($urandom_range(0, 1) == 1) pulse(m & NREQ'($urandom()), 0, '0);
      while (pend_m != '0)
        serve($urandom_range(0, 2), $urandom_range(0, 4), NP'($urandom()), 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
